// File: rtl/cacheline_adapter.sv
// rtl/cacheline_adapter.sv - 256-bit cache line to 4x64-bit banked-memory burst adapter
module cacheline_adapter (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  ufp_addr,
    input  logic         ufp_read,
    input  logic         ufp_write,
    input  logic [255:0] ufp_wdata,
    output logic [255:0] ufp_rdata,
    output logic         ufp_resp,
    output logic [31:0]  bmem_addr,
    output logic         bmem_read,
    output logic         bmem_write,
    output logic [63:0]  bmem_wdata,
    input  logic         bmem_ready,
    input  logic [31:0]  bmem_raddr,
    input  logic [63:0]  bmem_rdata,
    input  logic         bmem_rvalid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_REQ   = 3'd1,
        RD_WAIT  = 3'd2,
        WR_BURST = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [1:0]     cnt;
    logic [31:0]    line_addr;
    logic [255:0]   line_wdata;
    logic           beat_hit;
    logic           addr_lsb_unused;

    // The low address bits only select bytes within the line.
    assign addr_lsb_unused = ^ufp_addr[4:0];

    // Only beats tagged with our line address count; stray or stale ones are dropped.
    assign beat_hit = (state == RD_WAIT) && bmem_rvalid && (bmem_raddr == line_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 2'd0;
            line_addr  <= 32'h0;
            line_wdata <= 256'h0;
            ufp_rdata  <= 256'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (ufp_read) begin
                        line_addr <= {ufp_addr[31:5], 5'b0};
                        cnt       <= 2'd0;
                    end else if (ufp_write) begin
                        line_addr  <= {ufp_addr[31:5], 5'b0};
                        line_wdata <= ufp_wdata;
                        cnt        <= 2'd0;
                    end
                end
                RD_WAIT: begin
                    if (beat_hit) begin
                        ufp_rdata[{cnt, 6'b0} +: 64] <= bmem_rdata;
                        cnt                          <= cnt + 2'd1;
                    end
                end
                WR_BURST: begin
                    if (bmem_ready) begin
                        cnt <= cnt + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ufp_read) begin
                    state_next = RD_REQ;
                end else if (ufp_write) begin
                    state_next = WR_BURST;
                end
            end
            RD_REQ: begin
                if (bmem_ready) state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (beat_hit && (cnt == 2'd3)) state_next = RESP;
            end
            WR_BURST: begin
                if (bmem_ready && (cnt == 2'd3)) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ufp_resp   = 1'b0;
        bmem_addr  = 32'h0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = 64'h0;
        case (state)
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = line_addr;
            end
            RD_WAIT: begin
                bmem_addr = line_addr;
            end
            WR_BURST: begin
                bmem_write = 1'b1;
                bmem_addr  = line_addr;
                bmem_wdata = line_wdata[{cnt, 6'b0} +: 64];
            end
            RESP:    ufp_resp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cacheline_adapter.sv
// tb/tb_cacheline_adapter.sv - directed self-checking bench for cacheline_adapter
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  ufp_addr;
    logic         ufp_read;
    logic         ufp_write;
    logic [255:0] ufp_wdata;
    logic [255:0] ufp_rdata;
    logic         ufp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;

    int n_assert = 0;
    int n_fail   = 0;
    int rd_cyc   = 0;
    int wr_cyc   = 0;
    int resp_cyc = 0;
    int both_cyc = 0;

    cacheline_adapter dut (
        .clk        (clk),
        .rst        (rst),
        .ufp_addr   (ufp_addr),
        .ufp_read   (ufp_read),
        .ufp_write  (ufp_write),
        .ufp_wdata  (ufp_wdata),
        .ufp_rdata  (ufp_rdata),
        .ufp_resp   (ufp_resp),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe cycle counters, sampled with the pre-edge output values.
    always @(posedge clk) begin
        if (bmem_read)              rd_cyc++;
        if (bmem_write)             wr_cyc++;
        if (ufp_resp)               resp_cyc++;
        if (bmem_read && bmem_write) both_cyc++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_line(input string tag, input logic [31:0] a, input logic [255:0] line,
                             input logic also_write);
        int r0;
        int p0;
        int w0;
        r0 = rd_cyc;
        p0 = resp_cyc;
        w0 = wr_cyc;
        ufp_addr   = a;
        ufp_read   = 1'b1;
        ufp_write  = also_write;
        ufp_wdata  = {4{64'hFFFF_0000_FFFF_0000}};
        bmem_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_req_read"}, 256'(bmem_read), 256'(1));
        chk({tag, "_req_write"}, 256'(bmem_write), 256'(0));
        chk({tag, "_req_addr"}, 256'(bmem_addr), 256'({a[31:5], 5'b0}));
        @(negedge clk);
        chk({tag, "_wait_read"}, 256'(bmem_read), 256'(0));
        for (int k = 0; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = {a[31:5], 5'b0};
            bmem_rdata  = line[k*64 +: 64];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        chk({tag, "_resp"}, 256'(ufp_resp), 256'(1));
        chk({tag, "_rdata"}, ufp_rdata, line);
        ufp_read  = 1'b0;
        ufp_write = 1'b0;
        @(negedge clk);
        chk({tag, "_resp_drop"}, 256'(ufp_resp), 256'(0));
        chk({tag, "_idle_addr"}, 256'(bmem_addr), 256'(0));
        chk({tag, "_rdata_hold"}, ufp_rdata, line);
        chk({tag, "_read_cycles"}, 256'(rd_cyc - r0), 256'(1));
        chk({tag, "_resp_cycles"}, 256'(resp_cyc - p0), 256'(1));
        chk({tag, "_write_cycles"}, 256'(wr_cyc - w0), 256'(0));
    endtask

    localparam logic [255:0] LINE_A = {64'hA3A3_3333_0000_0003, 64'hA2A2_2222_0000_0002,
                                       64'hA1A1_1111_0000_0001, 64'hA0A0_0000_0000_0000};
    localparam logic [255:0] LINE_D = {64'hD3D3_0303_3030_3333, 64'hD2D2_0202_2020_2222,
                                       64'hD1D1_0101_1010_1111, 64'hD0D0_0000_0000_0000};
    localparam logic [255:0] LINE_B = {64'hBBBB_0000_0000_0003, 64'hBBBB_0000_0000_0002,
                                       64'hBBBB_0000_0000_0001, 64'hBBBB_0000_0000_0000};
    localparam logic [255:0] LINE_C = {64'hC3C3_C3C3_C3C3_C3C3, 64'hC2C2_C2C2_C2C2_C2C2,
                                       64'hC1C1_C1C1_C1C1_C1C1, 64'hC0C0_C0C0_C0C0_C0C0};
    localparam logic [255:0] LINE_E = {64'hE3E3_0000_1111_2222, 64'hE2E2_0000_1111_2222,
                                       64'hE1E1_0000_1111_2222, 64'hE0E0_0000_1111_2222};
    localparam logic [255:0] LINE_F = {64'h0F0F_0F0F_0000_0003, 64'h0F0F_0F0F_0000_0002,
                                       64'h0F0F_0F0F_0000_0001, 64'h0F0F_0F0F_0000_0000};

    initial begin
        int          w0;
        int          p0;
        int          r0;
        int          j;
        bit          v4 [8];
        bit          good4 [8];
        logic [31:0] a4;

        rst         = 1'b1;
        ufp_addr    = 32'h0;
        ufp_read    = 1'b0;
        ufp_write   = 1'b0;
        ufp_wdata   = 256'h0;
        bmem_ready  = 1'b0;
        bmem_raddr  = 32'h0;
        bmem_rdata  = 64'h0;
        bmem_rvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_resp", 256'(ufp_resp), 256'(0));
        chk("rst_read", 256'(bmem_read), 256'(0));
        chk("rst_write", 256'(bmem_write), 256'(0));
        chk("rst_addr", 256'(bmem_addr), 256'(0));
        chk("rst_wdata", 256'(bmem_wdata), 256'(0));
        chk("rst_rdata", ufp_rdata, 256'h0);
        rst = 1'b0;
        @(negedge clk);

        // Basic read, unaligned request address.
        read_line("rd1", 32'h0000_1234, LINE_A, 1'b0);

        // Write with ready held high; a stray beat during the burst must not touch rdata.
        w0 = wr_cyc;
        ufp_addr   = 32'h0000_0ABC;
        ufp_wdata  = LINE_D;
        ufp_write  = 1'b1;
        bmem_ready = 1'b1;
        @(negedge clk);
        bmem_rvalid = 1'b1;
        bmem_raddr  = 32'h0000_0AA0;
        bmem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        for (int i = 0; i < 4; i++) begin
            chk("wr1_write", 256'(bmem_write), 256'(1));
            chk("wr1_addr", 256'(bmem_addr), 256'(32'h0000_0AA0));
            chk("wr1_wdata", 256'(bmem_wdata), 256'(LINE_D[i*64 +: 64]));
            chk("wr1_no_resp", 256'(ufp_resp), 256'(0));
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        chk("wr1_resp", 256'(ufp_resp), 256'(1));
        chk("wr1_write_end", 256'(bmem_write), 256'(0));
        ufp_write = 1'b0;
        @(negedge clk);
        chk("wr1_write_cycles", 256'(wr_cyc - w0), 256'(4));
        chk("wr1_rdata_untouched", ufp_rdata, LINE_A);

        // Write with ready toggling: each beat held through its stall cycle.
        w0 = wr_cyc;
        p0 = resp_cyc;
        ufp_addr  = 32'h0000_4460;
        ufp_wdata = LINE_D;
        ufp_write = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk("wr2_write", 256'(bmem_write), 256'(1));
            chk("wr2_wdata", 256'(bmem_wdata), 256'(LINE_D[((i + 1) / 2)*64 +: 64]));
            chk("wr2_no_resp", 256'(ufp_resp), 256'(0));
            bmem_ready = (i % 2 == 0);
            @(negedge clk);
        end
        chk("wr2_resp", 256'(ufp_resp), 256'(1));
        ufp_write  = 1'b0;
        bmem_ready = 1'b1;
        @(negedge clk);
        chk("wr2_write_cycles", 256'(wr_cyc - w0), 256'(7));
        chk("wr2_resp_cycles", 256'(resp_cyc - p0), 256'(1));

        // Read with a stalled request, rvalid gaps and one mistagged beat.
        r0 = rd_cyc;
        a4 = 32'h0000_5A40;
        ufp_addr   = 32'h0000_5A5F;
        ufp_read   = 1'b1;
        bmem_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rd4_req_read", 256'(bmem_read), 256'(1));
            chk("rd4_req_addr", 256'(bmem_addr), 256'(a4));
            bmem_ready = (i == 3);
            @(negedge clk);
        end
        chk("rd4_read_cycles", 256'(rd_cyc - r0), 256'(4));
        v4    = '{1, 0, 1, 1, 0, 0, 1, 1};
        good4 = '{1, 0, 0, 1, 0, 0, 1, 1};
        j = 0;
        for (int i = 0; i < 8; i++) begin
            bmem_rvalid = v4[i];
            bmem_raddr  = good4[i] ? a4 : (a4 + 32'h20);
            bmem_rdata  = good4[i] ? LINE_B[j*64 +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
            if (good4[i]) j++;
            @(negedge clk);
            if (i < 7) chk("rd4_no_early_resp", 256'(ufp_resp), 256'(0));
        end
        bmem_rvalid = 1'b0;
        chk("rd4_resp", 256'(ufp_resp), 256'(1));
        chk("rd4_rdata", ufp_rdata, LINE_B);
        ufp_read = 1'b0;
        @(negedge clk);
        chk("rd4_resp_drop", 256'(ufp_resp), 256'(0));

        // Simultaneous read and write: read wins.
        read_line("rdwr", 32'h0000_0100, LINE_F, 1'b1);

        // Reset after the second beat aborts the read; stale beats are discarded.
        p0 = resp_cyc;
        ufp_addr   = 32'h0000_2000;
        ufp_read   = 1'b1;
        bmem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_2000;
            bmem_rdata  = LINE_C[k*64 +: 64];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        ufp_read    = 1'b0;
        rst         = 1'b1;
        @(negedge clk);
        chk("abort_resp", 256'(ufp_resp), 256'(0));
        chk("abort_addr", 256'(bmem_addr), 256'(0));
        chk("abort_read", 256'(bmem_read), 256'(0));
        chk("abort_rdata", ufp_rdata, 256'h0);
        rst = 1'b0;
        for (int k = 2; k < 4; k++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h0000_2000;
            bmem_rdata  = LINE_C[k*64 +: 64];
            @(negedge clk);
        end
        bmem_rvalid = 1'b0;
        @(negedge clk);
        chk("abort_stale_rdata", ufp_rdata, 256'h0);
        chk("abort_no_resp", 256'(resp_cyc - p0), 256'(0));
        read_line("rd_after_rst", 32'h0000_3008, LINE_E, 1'b0);

        chk("never_both_strobes", 256'(both_cyc), 256'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
